// File: rtl/frame_load_controller.sv
// Frame load controller: receives one frame of pixel bytes, writes them to
// the frame buffer, starts the edge engine and waits for it to finish.
module frame_load_controller #(
    parameter int unsigned IMG_WIDTH      = 64,
    parameter int unsigned IMG_HEIGHT     = 64,
    parameter int unsigned ADDR_W         = 12,
    parameter logic [7:0]  START_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byteValid,
    input  logic [7:0]        byteData,
    input  logic              csActive,
    input  logic              engineDone,
    output logic              memWriteEnable,
    output logic [ADDR_W-1:0] memWriteAddr,
    output logic [7:0]        memWriteData,
    output logic              engineStart,
    output logic              busy,
    output logic              frameDone,
    output logic              frameError,
    output logic [1:0]        errorCode
);

    localparam int unsigned NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Last pixel is detected on the current count so the counter never wraps,
    // even when the frame exactly fills the address space.
    localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TRUNC   = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    // Frame sequencing FSM with registered strobes, status and write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pix_cnt        <= '0;
            tmo_cnt        <= '0;
            memWriteEnable <= 1'b0;
            memWriteAddr   <= '0;
            memWriteData   <= '0;
            engineStart    <= 1'b0;
            busy           <= 1'b0;
            frameDone      <= 1'b0;
            frameError     <= 1'b0;
            errorCode      <= ERR_NONE;
        end else begin
            memWriteEnable <= 1'b0;
            engineStart    <= 1'b0;
            frameDone      <= 1'b0;

            case (state)
                IDLE: begin
                    if (byteValid && (byteData == START_BYTE)) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        pix_cnt    <= '0;
                        frameError <= 1'b0;
                        errorCode  <= ERR_NONE;
                    end
                end

                LOAD: begin
                    if (byteValid) begin
                        memWriteEnable <= 1'b1;
                        memWriteAddr   <= pix_cnt;
                        memWriteData   <= byteData;
                    end
                    // A byte arriving with the chip-select drop is counted
                    // before truncation is judged.
                    if (byteValid && (pix_cnt == LAST_PIXEL)) begin
                        state       <= START;
                        engineStart <= 1'b1;
                    end else begin
                        if (byteValid) begin
                            pix_cnt <= pix_cnt + ADDR_W'(1);
                        end
                        if (!csActive) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frameError <= 1'b1;
                            errorCode  <= ERR_TRUNC;
                        end
                    end
                end

                START: begin
                    if (byteValid) begin
                        frameError <= 1'b1;
                        errorCode  <= ERR_OVERRUN;
                    end
                    tmo_cnt <= '0;
                    state   <= BUSY;
                end

                BUSY: begin
                    // Overrun is flagged first so a simultaneous timeout overrides it.
                    if (byteValid) begin
                        frameError <= 1'b1;
                        errorCode  <= ERR_OVERRUN;
                    end
                    if (engineDone) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        frameDone <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frameError <= 1'b1;
                        errorCode  <= ERR_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_load_controller.md
# frame_load_controller

Sequences one image frame through the accelerator: consumes the byte stream produced by the SPI receiver (already synchronized into the system clock domain), writes pixel bytes into the frame buffer at linear addresses, launches the edge-detection engine once the frame is complete, and supervises it until done. Sits between the SPI receive path and the frame buffer / Sobel engine. Reports completion, protocol errors and engine timeouts to the host-facing status logic.

## Interface

- IMG_WIDTH, 64, pixels per row
- IMG_HEIGHT, 64, rows per frame
- ADDR_W, 12, frame buffer address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT
- START_BYTE, 8'hA5, header byte that opens a frame
- TIMEOUT_CYCLES, 1048576, max clk cycles allowed in BUSY before timeout
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- byteValid  input  1  one-cycle pulse: byteData holds a new received byte
- byteData  input  8  received byte
- csActive  input  1  high while SPI chip select is asserted (synchronized)
- engineDone  input  1  one-cycle pulse from the engine when processing finishes
- memWriteEnable  output  1  frame buffer write strobe
- memWriteAddr  output  ADDR_W  frame buffer write address
- memWriteData  output  8  frame buffer write data
- engineStart  output  1  one-cycle start pulse to the engine
- busy  output  1  high in LOAD, START, BUSY
- frameDone  output  1  one-cycle pulse on successful completion
- frameError  output  1  sticky error flag
- errorCode  output  2  00 none, 01 truncated frame, 10 overrun, 11 engine timeout

## Operation

- States: IDLE, LOAD, START, BUSY, DONE.
- IDLE: byteValid with byteData == START_BYTE -> LOAD, clears frameError/errorCode, pixel counter to 0. Any other byte ignored.
- LOAD: each byteValid writes byteData at address = pixel counter, counter increments. Write of pixel IMG_WIDTH*IMG_HEIGHT-1 -> START. Header byte value inside LOAD is pixel data, not a restart.
- LOAD, csActive low before final pixel: frameError=1, errorCode=01 -> IDLE, no engineStart. If byteValid and csActive-low coincide, the byte is written first, then truncation is judged on the updated count (last pixel + cs drop same cycle = success).
- START: engineStart=1 for exactly one cycle, timeout counter cleared -> BUSY.
- BUSY: timeout counter increments each cycle. engineDone -> DONE. Counter reaching TIMEOUT_CYCLES-1 without engineDone: errorCode=11, frameError=1 -> IDLE. engineDone on that same cycle wins (-> DONE, no error).
- byteValid in START or BUSY: byte dropped, errorCode=10, frameError=1, state unaffected (frame still completes). Later timeout overwrites code with 11.
- DONE: frameDone=1 for one cycle -> IDLE.
- engineDone outside BUSY ignored.
- Pixel counter width ADDR_W; never wraps (leaves LOAD at last pixel).

## Timing

- Reset values: state IDLE, all strobes 0, memWriteAddr 0, memWriteData 0, frameError 0, errorCode 00, busy 0.
- memWriteEnable/Addr/Data registered: asserted the cycle after byteValid, held one cycle; addr/data hold last values otherwise.
- Last pixel byteValid at cycle n -> write at n+1, engineStart at n+1 (state START), BUSY from n+2.
- engineDone at cycle m -> frameDone at m+1; busy low from m+1.
- Back-to-back byteValid every cycle supported in LOAD.
- Reset asserted mid-frame aborts immediately to reset values; no error flagged.

## Test plan

- IMG_WIDTH=4, IMG_HEIGHT=2: send A5 then bytes 10..17 -> 8 writes addr 0..7 data 10..17, one engineStart; engineDone 5 cycles later -> frameDone one cycle after, frameError 0.
- Bytes 3C, 00 in IDLE then A5, 8 pixels -> no writes for 3C/00; exactly 8 writes starting at addr 0.
- A5 then 5 pixels, csActive drops -> frameError 1, errorCode 01, no engineStart; next A5 clears error.
- Full frame, byte 55 during BUSY -> no write, errorCode 10, frameDone still pulses on engineDone.
- TIMEOUT_CYCLES=16, never assert engineDone -> errorCode 11 exactly 16 cycles after entering BUSY, state IDLE; repeat with engineDone on cycle 16 -> frameDone, no error.
- Reset asserted after 3 pixels, then full frame -> writes restart at addr 0, normal completion.
